// File: rtl/chacha_cfg_pkg.sv
// Shared types and constants for the ChaCha20 session configuration master.
package chacha_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      RESP,
      NEXT,
      DONE
   } state_t;

   typedef enum logic {
      TX,
      RX
   } bank_t;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam int         NUM_WORDS     = 13;
   localparam logic [3:0] LAST_IDX      = 4'(NUM_WORDS - 1);

endpackage

// File: rtl/chacha_cfg_sequencer_if.sv
// AXI4-Lite write channels (AW, W, B) between the sequencer and the interconnect.
interface chacha_cfg_sequencer_if;

   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;

   modport master (
      output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      output m_axi_bready,
      input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
   );

   modport slave (
      input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
      input  m_axi_bready,
      output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
   );

endinterface

// File: rtl/axil_single_writer.sv
// Handshake engine for a single AXI4-Lite write: raises AW and W together,
// retires each on its own ready, then waits for the B response.
module axil_single_writer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_data,
   output logic        o_addr_done,
   output logic        o_ack,
   output logic [1:0]  o_resp,
   chacha_cfg_sequencer_if.master m_axi
);

   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic [31:0] r_awaddr;
   logic [31:0] r_wdata;

   logic w_aw_fire;
   logic w_w_fire;

   assign w_aw_fire = r_awvalid & m_axi.m_axi_awready;
   assign w_w_fire  = r_wvalid & m_axi.m_axi_wready;

   // Address phase ends on the edge where the last outstanding valid handshakes.
   assign o_addr_done = (r_awvalid | r_wvalid)
                      & (~r_awvalid | m_axi.m_axi_awready)
                      & (~r_wvalid | m_axi.m_axi_wready);
   assign o_ack  = r_bready & m_axi.m_axi_bvalid;
   assign o_resp = m_axi.m_axi_bresp;

   assign m_axi.m_axi_awaddr  = r_awaddr;
   assign m_axi.m_axi_awprot  = 3'b000;
   assign m_axi.m_axi_awvalid = r_awvalid;
   assign m_axi.m_axi_wdata   = r_wdata;
   assign m_axi.m_axi_wstrb   = 4'hF;
   assign m_axi.m_axi_wvalid  = r_wvalid;
   assign m_axi.m_axi_bready  = r_bready;

   // Channel valids/bready; address and data only load on a new request so they
   // stay stable for the whole time their valid is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
      end else begin
         if (i_req) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_awaddr  <= i_addr;
            r_wdata   <= i_data;
         end else begin
            if (w_aw_fire) r_awvalid <= 1'b0;
            if (w_w_fire)  r_wvalid  <= 1'b0;
         end
         if (o_addr_done) begin
            r_bready <= 1'b1;
         end else if (o_ack) begin
            r_bready <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/chacha_cfg_sequencer.sv
// Loads a ChaCha20 key/nonce/counter into the TX then RX register banks over
// AXI4-Lite, enabling each bank with its final write.
module chacha_cfg_sequencer
   import chacha_cfg_pkg::*;
#(
   parameter logic [31:0] TX_BASE     = 32'h0000_0000,
   parameter logic [31:0] RX_BASE     = 32'h0000_1000,
   parameter logic [7:0]  CTRL_OFS    = 8'h00,
   parameter logic [7:0]  KEY_OFS     = 8'h10,
   parameter logic [7:0]  NONCE_OFS   = 8'h30,
   parameter logic [7:0]  CTR_OFS     = 8'h3C,
   parameter logic [31:0] CTRL_ENABLE = 32'h0000_0001
) (
   input  logic         s_axi_aclk,
   input  logic         s_axi_aresetn,
   input  logic         i_start,
   input  logic [255:0] i_key,
   input  logic [95:0]  i_nonce,
   input  logic [31:0]  i_counter,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_err,
   output logic [31:0]  o_err_addr,
   chacha_cfg_sequencer_if.master m_axi
);

   state_t       r_state;
   bank_t        r_bank;
   logic [3:0]   r_idx;
   logic [255:0] r_key;
   logic [95:0]  r_nonce;
   logic [31:0]  r_counter;
   logic [31:0]  r_cur_addr;
   logic         r_busy;
   logic         r_done;
   logic         r_err;
   logic [31:0]  r_err_addr;

   logic         w_req;
   logic [3:0]   w_nidx;
   bank_t        w_nbank;
   logic [255:0] w_src_key;
   logic [95:0]  w_src_nonce;
   logic [31:0]  w_src_ctr;
   logic [7:0]   w_offset;
   logic [31:0]  w_req_addr;
   logic [31:0]  w_req_data;
   logic         w_addr_done;
   logic         w_ack;
   logic [1:0]   w_resp;

   // Decide whether a new write is launched this edge and build its address/data;
   // the first word of a session comes straight from the inputs being latched.
   always_comb begin
      w_req       = 1'b0;
      w_nidx      = r_idx;
      w_nbank     = r_bank;
      w_src_key   = r_key;
      w_src_nonce = r_nonce;
      w_src_ctr   = r_counter;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_req       = 1'b1;
               w_nidx      = 4'd0;
               w_nbank     = TX;
               w_src_key   = i_key;
               w_src_nonce = i_nonce;
               w_src_ctr   = i_counter;
            end
         end
         NEXT: begin
            if (r_idx < LAST_IDX) begin
               w_req  = 1'b1;
               w_nidx = r_idx + 4'd1;
            end else if (r_bank == TX) begin
               w_req   = 1'b1;
               w_nidx  = 4'd0;
               w_nbank = RX;
            end
         end
         default: ;
      endcase

      w_offset   = CTRL_OFS;
      w_req_data = CTRL_ENABLE;
      if (w_nidx < 4'd8) begin
         w_offset   = KEY_OFS + {3'b000, w_nidx[2:0], 2'b00};
         w_req_data = w_src_key[32*w_nidx[2:0] +: 32];
      end else if (w_nidx < 4'd11) begin
         w_offset   = NONCE_OFS + {4'b0000, w_nidx[1:0], 2'b00};
         w_req_data = w_src_nonce[32*w_nidx[1:0] +: 32];
      end else if (w_nidx == 4'd11) begin
         w_offset   = CTR_OFS;
         w_req_data = w_src_ctr;
      end
      w_req_addr = ((w_nbank == TX) ? TX_BASE : RX_BASE) + {24'h000000, w_offset};
   end

   axil_single_writer u_writer (
      .clk         (s_axi_aclk),
      .rst_n       (s_axi_aresetn),
      .i_req       (w_req),
      .i_addr      (w_req_addr),
      .i_data      (w_req_data),
      .o_addr_done (w_addr_done),
      .o_ack       (w_ack),
      .o_resp      (w_resp),
      .m_axi       (m_axi)
   );

   // Session FSM with registered status outputs; aborts on the first non-OKAY response.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state    <= IDLE;
         r_bank     <= TX;
         r_idx      <= '0;
         r_key      <= '0;
         r_nonce    <= '0;
         r_counter  <= '0;
         r_cur_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_req) begin
            r_idx      <= w_nidx;
            r_bank     <= w_nbank;
            r_cur_addr <= w_req_addr;
         end
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_key      <= i_key;
                  r_nonce    <= i_nonce;
                  r_counter  <= i_counter;
                  r_err      <= 1'b0;
                  r_err_addr <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ADDR;
               end
            end
            ADDR: begin
               if (w_addr_done) r_state <= RESP;
            end
            RESP: begin
               if (w_ack) begin
                  if (w_resp == AXI_RESP_OKAY) begin
                     r_state <= NEXT;
                  end else begin
                     if (!r_err) begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_cur_addr;
                     end
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            NEXT: begin
               if (w_req) begin
                  r_state <= ADDR;
               end else begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_err_addr = r_err_addr;

endmodule

// File: tb/tb_chacha_cfg_sequencer.sv
// Scoreboard bench for chacha_cfg_sequencer: a reference model queues the
// expected write list per session, a monitor checks what appears on the bus.
module tb_chacha_cfg_sequencer;

   logic         clock = 1'b0;
   logic         resetN = 1'b0;
   logic         iStart = 1'b0;
   logic [255:0] iKey = '0;
   logic [95:0]  iNonce = '0;
   logic [31:0]  iCounter = '0;
   logic         oBusy;
   logic         oDone;
   logic         oErr;
   logic [31:0]  oErrAddr;

   chacha_cfg_sequencer_if axi ();

   chacha_cfg_sequencer dut (
      .s_axi_aclk    (clock),
      .s_axi_aresetn (resetN),
      .i_start       (iStart),
      .i_key         (iKey),
      .i_nonce       (iNonce),
      .i_counter     (iCounter),
      .o_busy        (oBusy),
      .o_done        (oDone),
      .o_err         (oErr),
      .o_err_addr    (oErrAddr),
      .m_axi         (axi)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      bit          err;
      logic [31:0] errAddr;
      int          writes;
      int          latency;
   } done_t;

   wr_t   expQ[$];
   done_t doneQ[$];

   int vectors = 0;
   int miscompares = 0;
   int cycleCount = 0;
   int startCycle = 0;
   int writesSeen = 0;
   int bSeen = 0;

   // Slave configuration: 0 random readies, 1 zero-wait, 2 wready 3 cycles ahead of awready
   int          readyMode = 1;
   int          bDelayCfg = 0;
   int          bCnt = 0;
   logic [31:0] errAddrCfg = 32'hFFFF_FFFF;

   localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

   // Free-running cycle count used for latency measurement
   always @(posedge clock) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int wordOffset(input int w);
      if (w < 8)       return 16 + 4 * w;
      else if (w < 11) return 48 + 4 * (w - 8);
      else if (w == 11) return 60;
      else             return 0;
   endfunction

   // Reference model: 13 words per bank, TX bank first, stop after a failing write
   task automatic modelSession(input logic [255:0] key, input logic [95:0] nonce,
                               input logic [31:0] ctr, input logic [31:0] badAddr, input int latency);
      done_t d;
      wr_t   e;
      logic [31:0] base;
      d.err = 1'b0; d.errAddr = '0; d.writes = 0; d.latency = latency;
      for (int b = 0; b < 2 && !d.err; b++) begin
         base = (b == 0) ? 32'h0000_0000 : 32'h0000_1000;
         for (int w = 0; w < 13 && !d.err; w++) begin
            e.addr = base + 32'(wordOffset(w));
            if (w < 8)       e.data = key[32*w +: 32];
            else if (w < 11) e.data = nonce[32*(w-8) +: 32];
            else if (w == 11) e.data = ctr;
            else             e.data = 32'h0000_0001;
            expQ.push_back(e);
            d.writes++;
            if (e.addr == badAddr) begin
               d.err = 1'b1;
               d.errAddr = e.addr;
            end
         end
      end
      doneQ.push_back(d);
   endtask

   function automatic logic [255:0] randKey();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
      return k;
   endfunction

   function automatic logic [95:0] randNonce();
      logic [95:0] n;
      for (int i = 0; i < 3; i++) n[32*i +: 32] = $urandom();
      return n;
   endfunction

   task automatic configSlave(input int mode, input int bDelay, input logic [31:0] bad);
      readyMode = mode;
      bDelayCfg = bDelay;
      bCnt = bDelay;
      errAddrCfg = bad;
   endtask

   // Slave model: samples handshakes at negedge, updates its drives just after posedge
   initial begin
      bit sAw, sW, sB, sAwValid, gotAw, gotW;
      logic [31:0] sAddr, slvAddr;
      int awCnt;
      gotAw = 0; gotW = 0; awCnt = 0; slvAddr = '0;
      axi.m_axi_awready = 1'b0;
      axi.m_axi_wready  = 1'b0;
      axi.m_axi_bvalid  = 1'b0;
      axi.m_axi_bresp   = 2'b00;
      forever begin
         @(negedge clock);
         sAw = axi.m_axi_awvalid && axi.m_axi_awready;
         sW  = axi.m_axi_wvalid && axi.m_axi_wready;
         sB  = axi.m_axi_bvalid && axi.m_axi_bready;
         sAwValid = axi.m_axi_awvalid;
         sAddr = axi.m_axi_awaddr;
         @(posedge clock);
         #1;
         if (!resetN) begin
            gotAw = 0; gotW = 0; awCnt = 0; bCnt = bDelayCfg;
            axi.m_axi_bvalid = 1'b0;
            axi.m_axi_awready = 1'b0;
            axi.m_axi_wready = 1'b0;
            continue;
         end
         if (sAw) begin
            gotAw = 1; slvAddr = sAddr; awCnt = 0;
         end else if (sAwValid) begin
            awCnt++;
         end
         if (sW) gotW = 1;
         if (sB) axi.m_axi_bvalid = 1'b0;
         if (gotAw && gotW) begin
            if (bCnt == 0) begin
               axi.m_axi_bvalid = 1'b1;
               axi.m_axi_bresp  = (slvAddr == errAddrCfg) ? 2'b10 : 2'b00;
               gotAw = 0; gotW = 0;
               bCnt = bDelayCfg;
            end else begin
               bCnt--;
            end
         end
         case (readyMode)
            0: begin
               axi.m_axi_awready = 1'($urandom_range(0, 1));
               axi.m_axi_wready  = 1'($urandom_range(0, 1));
            end
            2: begin
               axi.m_axi_wready  = 1'b1;
               axi.m_axi_awready = (awCnt >= 3);
            end
            default: begin
               axi.m_axi_awready = 1'b1;
               axi.m_axi_wready  = 1'b1;
            end
         endcase
      end
   end

   // Monitor: pairs AW/W handshakes into writes, pops the scoreboard, checks completion
   initial begin
      bit haveA, haveW, prevAwPend, prevWPend, prevBWait;
      logic [31:0] capA, capW, prevAwAddr, prevWData;
      wr_t e;
      done_t d;
      haveA = 0; haveW = 0; prevAwPend = 0; prevWPend = 0; prevBWait = 0;
      forever begin
         @(negedge clock);
         if (!resetN) begin
            haveA = 0; haveW = 0; prevAwPend = 0; prevWPend = 0; prevBWait = 0;
            continue;
         end
         if (prevAwPend) begin
            checkOutput("awvalid held", 32'(axi.m_axi_awvalid), 32'd1);
            checkOutput("awaddr stable", axi.m_axi_awaddr, prevAwAddr);
         end
         if (prevWPend) begin
            checkOutput("wvalid held", 32'(axi.m_axi_wvalid), 32'd1);
            checkOutput("wdata stable", axi.m_axi_wdata, prevWData);
         end
         if (prevBWait) checkOutput("bready held", 32'(axi.m_axi_bready), 32'd1);
         if (axi.m_axi_awvalid && axi.m_axi_awready) begin
            capA = axi.m_axi_awaddr; haveA = 1;
         end
         if (axi.m_axi_wvalid && axi.m_axi_wready) begin
            capW = axi.m_axi_wdata; haveW = 1;
         end
         prevAwPend = axi.m_axi_awvalid && !axi.m_axi_awready;
         prevWPend  = axi.m_axi_wvalid && !axi.m_axi_wready;
         prevBWait  = axi.m_axi_bready && !axi.m_axi_bvalid;
         prevAwAddr = axi.m_axi_awaddr;
         prevWData  = axi.m_axi_wdata;
         if (axi.m_axi_bvalid && axi.m_axi_bready) bSeen++;
         if (haveA && haveW) begin
            haveA = 0; haveW = 0;
            writesSeen++;
            if (expQ.size() == 0) begin
               vectors++; miscompares++;
               $display("[TB] FAIL unexpected write: addr %h data %h, none required", capA, capW);
            end else begin
               e = expQ.pop_front();
               checkOutput("write addr", capA, e.addr);
               checkOutput("write data", capW, e.data);
            end
         end
         if (oDone) begin
            if (doneQ.size() == 0) begin
               vectors++; miscompares++;
               $display("[TB] FAIL unexpected done pulse: got 1 required 0");
            end else begin
               d = doneQ.pop_front();
               checkOutput("err at done", 32'(oErr), 32'(d.err));
               checkOutput("err_addr at done", oErrAddr, d.errAddr);
               checkOutput("write count", 32'(writesSeen), 32'(d.writes));
               checkOutput("B handshake count", 32'(bSeen), 32'(d.writes));
               checkOutput("busy at done", 32'(oBusy), 32'd0);
               checkOutput("leftover writes", 32'(expQ.size()), 32'd0);
               if (d.latency >= 0)
                  checkOutput("start-to-done latency", 32'(cycleCount - startCycle), 32'(d.latency));
               expQ.delete();
            end
         end
      end
   end

   task automatic pulseReset();
      @(negedge clock);
      resetN = 1'b0;
      repeat (2) @(negedge clock);
      expQ.delete();
      doneQ.delete();
      resetN = 1'b1;
      @(negedge clock);
   endtask

   // Issue one session start, queue its expected writes, then scramble the inputs
   task automatic applyStimulus(input logic [255:0] key, input logic [95:0] nonce,
                                input logic [31:0] ctr, input int latency);
      modelSession(key, nonce, ctr, errAddrCfg, latency);
      @(negedge clock);
      iKey = key; iNonce = nonce; iCounter = ctr;
      iStart = 1'b1;
      writesSeen = 0; bSeen = 0;
      startCycle = cycleCount;
      @(negedge clock);
      iStart = 1'b0;
      iKey = randKey(); iNonce = randNonce(); iCounter = $urandom();
      checkOutput("busy after start", 32'(oBusy), 32'd1);
      checkOutput("err cleared by start", 32'(oErr), 32'd0);
      checkOutput("err_addr cleared by start", oErrAddr, 32'd0);
   endtask

   task automatic waitDone(input int budget);
      int n;
      n = 0;
      while (!oDone && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (!oDone) begin
         vectors++; miscompares++;
         $display("[TB] FAIL done timeout: got no done within %0d cycles, required a pulse", budget);
         pulseReset();
      end else begin
         @(negedge clock);
      end
   endtask

   initial begin
      logic [255:0] keyA;
      logic [95:0]  nonceA;
      logic [31:0]  bad;
      int n;

      // Reset values
      repeat (3) @(negedge clock);
      checkOutput("reset busy", 32'(oBusy), 32'd0);
      checkOutput("reset done", 32'(oDone), 32'd0);
      checkOutput("reset err", 32'(oErr), 32'd0);
      checkOutput("reset err_addr", oErrAddr, 32'd0);
      checkOutput("reset awvalid", 32'(axi.m_axi_awvalid), 32'd0);
      checkOutput("reset wvalid", 32'(axi.m_axi_wvalid), 32'd0);
      checkOutput("reset bready", 32'(axi.m_axi_bready), 32'd0);
      checkOutput("reset awaddr", axi.m_axi_awaddr, 32'd0);
      checkOutput("reset wdata", axi.m_axi_wdata, 32'd0);
      resetN = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("awprot", 32'(axi.m_axi_awprot), 32'd0);
      checkOutput("wstrb", 32'(axi.m_axi_wstrb), 32'hF);

      // Zero-wait slave with the byte-pattern key
      for (int i = 0; i < 8; i++)
         keyA[32*i +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      nonceA = {32'h0000_004A, 32'h0000_0000, 32'h0900_0000};
      configSlave(1, 0, NO_ERR);
      applyStimulus(keyA, nonceA, 32'd1, 79);
      waitDone(400);

      // wready three cycles ahead of awready on every write
      configSlave(2, 0, NO_ERR);
      applyStimulus(randKey(), randNonce(), $urandom(), -1);
      waitDone(1000);

      // SLVERR on RX nonce word 1 aborts the session
      configSlave(0, 1, 32'h0000_1034);
      applyStimulus(randKey(), randNonce(), $urandom(), -1);
      waitDone(1500);
      checkOutput("err sticky after done", 32'(oErr), 32'd1);
      checkOutput("err_addr sticky", oErrAddr, 32'h0000_1034);

      // Start re-pulsed mid-session with a different key is ignored
      configSlave(1, 0, NO_ERR);
      applyStimulus(randKey(), randNonce(), $urandom(), 79);
      repeat (20) @(negedge clock);
      iKey = randKey(); iNonce = randNonce(); iStart = 1'b1;
      @(negedge clock);
      iStart = 1'b0;
      waitDone(400);

      // bvalid held off 10 cycles per write
      configSlave(1, 10, NO_ERR);
      applyStimulus(randKey(), randNonce(), $urandom(), 79 + 26 * 10);
      waitDone(800);

      // Asynchronous reset while awvalid is up in the fifth write
      configSlave(2, 0, NO_ERR);
      applyStimulus(randKey(), randNonce(), $urandom(), -1);
      n = 0;
      while (!(writesSeen == 4 && axi.m_axi_awvalid) && n < 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput("reached write 5", 32'(writesSeen), 32'd4);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("async reset awvalid", 32'(axi.m_axi_awvalid), 32'd0);
      checkOutput("async reset wvalid", 32'(axi.m_axi_wvalid), 32'd0);
      checkOutput("async reset bready", 32'(axi.m_axi_bready), 32'd0);
      checkOutput("async reset busy", 32'(oBusy), 32'd0);
      expQ.delete();
      doneQ.delete();
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      repeat (6) @(negedge clock);
      checkOutput("idle after reset awvalid", 32'(axi.m_axi_awvalid), 32'd0);
      checkOutput("idle after reset busy", 32'(oBusy), 32'd0);
      checkOutput("idle after reset done", 32'(oDone), 32'd0);

      // Randomized sessions: slave timing, response delay and optional error word
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1)
            bad = ($urandom_range(0, 1) == 1 ? 32'h0000_1000 : 32'h0000_0000)
                + 32'(wordOffset(int'($urandom_range(0, 12))));
         else
            bad = NO_ERR;
         configSlave(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), bad);
         applyStimulus(randKey(), randNonce(), $urandom(), -1);
         waitDone(2000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global timeout: simulation did not complete");
      $fatal(1, "[TB] global timeout");
   end

endmodule

// File: doc/chacha_cfg_sequencer.md
Name: chacha_cfg_sequencer

Overview:
AXI4-Lite write-only master that loads a ChaCha20 session (256-bit key, 96-bit nonce, 32-bit initial block counter) into the transmitter and receiver register banks, then enables both.
- Sits in front of the AXI interconnect as an alternative configuration master to the PS, so a session rekey needs one start pulse instead of 26 CPU writes.
- Transmitter is always written before receiver.
- In each bank the control/enable word is written last.

Parameters:
- TX_BASE, 32'h0000_0000, base address of the transmitter register bank.
- RX_BASE, 32'h0000_1000, base address of the receiver register bank.
- CTRL_OFS, 8'h00, control register offset.
- KEY_OFS, 8'h10, key word 0 offset; words 1-7 follow at +4 each.
- NONCE_OFS, 8'h30, nonce word 0 offset; words 1-2 follow at +4 each.
- CTR_OFS, 8'h3C, initial block counter offset.
- CTRL_ENABLE, 32'h0000_0001, value written to the control register.

Ports:
- s_axi_aclk  in  1  single clock
- s_axi_aresetn  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle request; sampled only in IDLE
- i_key  in  256  key; word i = i_key[32*i +: 32]
- i_nonce  in  96  nonce; word i = i_nonce[32*i +: 32]
- i_counter  in  32  initial block counter
- o_busy  out  1  high from the cycle after an accepted start until DONE
- o_done  out  1  one-cycle pulse at end of sequence (success or error)
- o_err  out  1  sticky; cleared by the next accepted start
- o_err_addr  out  32  address of the first write that returned non-OKAY
- m_axi_awaddr  out  32
- m_axi_awprot  out  3  constant 3'b000
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4  constant 4'hF
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset (async assert, sync deassert), all outputs zero:
  - busy, done, err, err_addr = 0
  - awvalid, wvalid, bready = 0; awaddr, wdata = 0
  - FSM = IDLE
- Reset mid-sequence drops valids immediately. The sequence is lost and a new start is required.
- Start accept: in IDLE, i_start=1 does the following on the same edge:
  - latches i_key, i_nonce, i_counter into internal registers (later input changes are ignored)
  - clears err and err_addr
  - sets idx=0, bank=TX
  - goes to ADDR
- start in any other state is ignored.
- Word index idx (0..12) within a bank:
  - 0-7 → key word idx at KEY_OFS+4*idx
  - 8-10 → nonce word idx-8 at NONCE_OFS+4*(idx-8)
  - 11 → counter at CTR_OFS
  - 12 → CTRL_ENABLE at CTRL_OFS
  - awaddr = bank base + offset (32-bit add, no wrap check)
- FSM:
  - IDLE → ADDR on accepted start.
  - ADDR: entered with awvalid=1, wvalid=1. Each valid drops independently on its own ready handshake. Both may complete in the same cycle or in either order. When both have completed → RESP. awaddr/wdata stay stable while their valid is high.
  - RESP: bready=1 and held until bvalid.
    - bresp==2'b00 → NEXT.
    - Otherwise, if err==0, set err=1 and err_addr=current awaddr → DONE (abort; remaining writes skipped, including the enable).
  - NEXT (1 cycle):
    - idx<12 → idx+1, back to ADDR.
    - idx==12 and bank==TX → bank=RX, idx=0, ADDR.
    - idx==12 and bank==RX → DONE.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- One outstanding transaction at a time; at most one write in flight.
- Cost per write: 1 ADDR cycle minimum + 1 RESP cycle minimum + 1 NEXT cycle. Total latency with zero-wait slave = 26*3 + 1 = 79 cycles from start to done.
- busy is 1 in ADDR/RESP/NEXT.
- A bvalid arriving while not in RESP is not accepted (bready=0).

Decomposition:
- Package chacha_cfg_pkg: FSM state enum (IDLE, ADDR, RESP, NEXT, DONE), AXI_RESP_OKAY constant, NUM_WORDS=13, bank enum (TX, RX).
- Sub-module axil_single_writer: AW/W/B handshake engine for one write. Interface: req, addr, data → ack, resp.
- chacha_cfg_sequencer holds the index/bank counters and word mux.

Test Plan:
- Zero-wait slave, key=32'h03020100 pattern per word, nonce={32'h4A,32'h0,32'h09000000}, counter=1, start → 26 writes in order: TX 0x10..0x2C, 0x30..0x38, 0x3C, 0x00, then the same at 0x1010..0x1000; data matches; done at cycle 79; err=0.
- Slave asserts wready 3 cycles before awready on every write → awaddr/wdata stable while valid; no duplicate writes; 26 B handshakes.
- Slave returns SLVERR on RX nonce word 1 (addr 0x1034) → sequence stops; err=1; err_addr=32'h0000_1034; done pulses; no write to 0x1000.
- start re-pulsed while busy with different key → ignored; written data equals the first key; next start after done clears err.
- Reset asserted while awvalid=1 in write 5 → awvalid/wvalid/bready drop asynchronously; busy=0; after release idle until new start.
- bvalid held off 10 cycles each write → bready stays high until accept; total latency = 79 + 26*10 cycles.
